gray_tree_scanner: RTL and testbench
====================================

# gray_tree_scanner

Readout sequencer for the bank of gray-coded channel counters built from double-edge flip-flops in the gray tree. On a start request it steps through every channel, drives the channel-select lines, captures the gray count with a two-sample stability check, and converts it to binary. It then presents the per-channel count delta since the previous scan on a valid/ready stream toward the serializer.

## Interface
- N_CH, default 8: number of channels scanned; must be ≥2.
- W, default 8: counter width in bits.
- SETTLE, default 2: cycles held in SELECT after ch_sel changes, before sampling; must be ≥1.
- MAX_RETRY, default 3: maximum number of mismatched sample pairs before a capture is forced.

- clk  input  1  scan clock; all state updates on the rising edge.
- rstb  input  1  asynchronous, active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- gray_in  input  W  gray count of the channel addressed by ch_sel, asynchronous to clk.
- ch_sel  output  clog2(N_CH)  channel address driven to the counter mux.
- busy  output  1  high in every state except IDLE.
- data_out  output  W  binary delta, (count − previous count of the same channel) mod 2^W.
- data_ch  output  clog2(N_CH)  channel index of data_out.
- data_err  output  1  high if the capture was forced after MAX_RETRY mismatches.
- data_valid  output  1  output word available.
- data_ready  input  1  downstream accepts the word.
- done  output  1  one-cycle pulse after the last channel is transferred.

## Operation
- States: IDLE, SELECT, SAMP0, SAMP1, CONV, OUT, DONE.
- IDLE, start=1: ch_sel←0, retry←0, go to SELECT. start=0: remain in IDLE.
- SELECT: count SETTLE cycles, then go to SAMP0.
- SAMP0: s0←gray_in, go to SAMP1.
- SAMP1: s1←gray_in.
  - s1==s0: go to CONV with err=0.
  - Mismatch and retry<MAX_RETRY−1: retry++, go back to SAMP0.
  - Mismatch and retry==MAX_RETRY−1: go to CONV using s1, with err=1.
- CONV: bin = gray2bin(s1), where b[W−1]=g[W−1] and b[i]=b[i+1]^g[i]. Register data_out = bin − prev[ch] (W-bit, modulo wrap). Set data_ch=ch_sel and data_err=err. Go to OUT.
- OUT: data_valid=1.
  - data_out, data_ch and data_err are held stable until a rising edge with data_ready=1.
  - On that edge: prev[ch]←bin and retry←0.
  - If ch_sel==N_CH−1, go to DONE. Otherwise ch_sel++ and go to SELECT.
- DONE: done=1 for one cycle, then go to IDLE. ch_sel returns to 0.
- prev[] is N_CH×W registers, cleared only by reset. The first scan after reset therefore reports absolute counts.
- Wrap: counter rollover is absorbed by the modulo subtraction. For example, prev=250, bin=4, W=8 gives data_out=10.

## Timing
- Reset values: ch_sel=0, busy=0, data_out=0, data_ch=0, data_err=0, data_valid=0, done=0, prev[]=0, state IDLE.
- Reset is asynchronous. Asserting rstb mid-scan aborts immediately with no partial transfer, and all outputs take their reset values.
- Latency: with start sampled at edge k and no retries, data_valid rises after edge k+SETTLE+3 (k+5 at default). Each retry adds 2 cycles.
- Channel-to-channel latency: the next data_valid rises SETTLE+3 edges after the transfer edge.
- data_valid=1 with data_ready=1 transfers on that edge, and data_valid drops after it unless the next word is ready. The next word cannot be ready, so there are no back-to-back words.
- data_ready is ignored outside OUT.
- start is ignored while busy. start held high continuously launches a new scan on the edge after DONE.
- The done pulse coincides with the DONE state. busy is still high during DONE and low from the following cycle.

## Test plan
- Basic scan: reset; gray_in = gray(10·ch) per channel; data_ready=1; pulse start.
  - Required: 8 words with data_ch 0..7, data_out=10·ch, data_err=0.
  - First data_valid after edge k+5; done pulse once; busy low afterwards.
- Delta and wrap: second scan with channel 3 counter = 4 and prev=250.
  - Required: data_out=10 for ch 3; all unchanged channels report 0.
- Backpressure: data_ready low for 7 cycles on channel 2.
  - Required: data_valid, data_out and data_ch held stable throughout; ch_sel stays 2; exactly one transfer occurs.
- Instability: toggle gray_in between each pair of samples.
  - Required: 3 sample pairs; word emitted with data_err=1 and data_out derived from the last s1.
  - Latency is 4 cycles more than nominal.
- Reset mid-scan: drop rstb during channel 4 OUT.
  - Required: all outputs 0 immediately (asynchronously).
  - Next scan reports absolute counts for all channels.
- start during busy: pulse start mid-scan.
  - Required: no effect; exactly 8 words and a single done pulse.

Source files
------------

// File: rtl/gray_tree_scanner.sv
// Readout sequencer for the gray-coded channel counter bank: selects each channel,
// double-samples the gray count, converts to binary and streams the per-channel delta.
module gray_tree_scanner #(
  parameter int N_CH      = 8,
  parameter int W         = 8,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 3,
  localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic [W-1:0]  gray_in,
  output logic [CW-1:0] ch_sel,
  output logic          busy,
  output logic [W-1:0]  data_out,
  output logic [CW-1:0] data_ch,
  output logic          data_err,
  output logic          data_valid,
  input  logic          data_ready,
  output logic          done
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SAMP0, S_SAMP1, S_CONV, S_OUT, S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_ch_sel;
  logic          r_busy;
  logic [W-1:0]  r_data_out;
  logic [CW-1:0] r_data_ch;
  logic          r_data_err;
  logic          r_data_valid;
  logic          r_done;
  logic [SW-1:0] r_settle;
  logic [RW-1:0] r_retry;
  logic [W-1:0]  r_s0;
  logic [W-1:0]  r_s1;
  logic          r_err;
  logic [W-1:0]  r_prev [N_CH];
  logic [W-1:0]  w_bin;

  // Binary bit i is the XOR of all gray bits at or above i.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_gray2bin
      assign w_bin[gi] = ^r_s1[W-1:gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state      <= S_IDLE;
      r_ch_sel     <= '0;
      r_busy       <= 1'b0;
      r_data_out   <= '0;
      r_data_ch    <= '0;
      r_data_err   <= 1'b0;
      r_data_valid <= 1'b0;
      r_done       <= 1'b0;
      r_settle     <= '0;
      r_retry      <= '0;
      r_s0         <= '0;
      r_s1         <= '0;
      r_err        <= 1'b0;
      for (int i = 0; i < N_CH; i++) r_prev[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ch_sel <= '0;
            r_retry  <= '0;
            r_settle <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_settle == SW'(SETTLE - 1)) r_state <= S_SAMP0;
          else r_settle <= r_settle + 1'b1;
        end
        S_SAMP0: begin
          r_s0    <= gray_in;
          r_state <= S_SAMP1;
        end
        S_SAMP1: begin
          r_s1 <= gray_in;
          if (gray_in == r_s0) begin
            r_err   <= 1'b0;
            r_state <= S_CONV;
          end else if (r_retry == RW'(MAX_RETRY - 1)) begin
            // Counter never settled: keep the latest sample and flag it.
            r_err   <= 1'b1;
            r_state <= S_CONV;
          end else begin
            r_retry <= r_retry + 1'b1;
            r_state <= S_SAMP0;
          end
        end
        S_CONV: begin
          r_data_out   <= w_bin - r_prev[r_ch_sel];
          r_data_ch    <= r_ch_sel;
          r_data_err   <= r_err;
          r_data_valid <= 1'b1;
          r_state      <= S_OUT;
        end
        S_OUT: begin
          if (data_ready) begin
            r_data_valid     <= 1'b0;
            r_prev[r_ch_sel] <= w_bin;
            r_retry          <= '0;
            if (r_ch_sel == CW'(N_CH - 1)) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ch_sel <= r_ch_sel + 1'b1;
              r_settle <= '0;
              r_state  <= S_SELECT;
            end
          end
        end
        S_DONE: begin
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_ch_sel <= '0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_sel     = r_ch_sel;
  assign busy       = r_busy;
  assign data_out   = r_data_out;
  assign data_ch    = r_data_ch;
  assign data_err   = r_data_err;
  assign data_valid = r_data_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_gray_tree_scanner.sv
// Scoreboard bench for gray_tree_scanner: expected words are queued at stimulus time
// and popped when the stream hands a word over.
module tb_gray_tree_scanner;
  localparam int N_CH      = 8;
  localparam int W         = 8;
  localparam int SETTLE    = 2;
  localparam int MAX_RETRY = 3;
  localparam int CW        = 3;

  typedef struct {
    logic [CW-1:0] ch;
    logic [W-1:0]  data;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  gray_in;
  logic [CW-1:0] ch_sel;
  logic          busy;
  logic [W-1:0]  data_out;
  logic [CW-1:0] data_ch;
  logic          data_err;
  logic          data_valid;
  logic          data_ready = 1'b1;
  logic          done;

  logic [W-1:0]  cnt    [N_CH];
  logic [W-1:0]  prev_m [N_CH];
  exp_t          sb [$];
  bit            tog = 1'b0;
  bit            inst_en = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            words_seen = 0;
  int            done_seen = 0;

  always #5 clk = ~clk;
  always @(negedge clk) tog <= ~tog;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Channel 0 can be made unstable by flipping bit 0 every cycle.
  assign gray_in = to_gray(cnt[ch_sel]) ^ {{(W-1){1'b0}}, tog & inst_en & (ch_sel == '0)};

  gray_tree_scanner #(.N_CH(N_CH), .W(W), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rstb(rstb), .start(start), .gray_in(gray_in), .ch_sel(ch_sel),
    .busy(busy), .data_out(data_out), .data_ch(data_ch), .data_err(data_err),
    .data_valid(data_valid), .data_ready(data_ready), .done(done)
  );

  // Stream monitor: a word present with ready high at the falling edge transfers next rise.
  always @(negedge clk) begin
    if (rstb) begin
      if (done) done_seen++;
      if (data_valid && data_ready) begin
        exp_t e;
        words_seen++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got ch=%0d data=%0d err=%0d, required none", data_ch, data_out, data_err);
        end else begin
          e = sb.pop_front();
          if (data_ch !== e.ch) begin
            errors++;
            $display("FAIL word_ch: got %0d, required %0d", data_ch, e.ch);
          end
          checks++;
          if (data_out !== e.data) begin
            errors++;
            $display("FAIL word_data ch%0d: got %0d, required %0d", e.ch, data_out, e.data);
          end
          checks++;
          if (data_err !== e.err) begin
            errors++;
            $display("FAIL word_err ch%0d: got %0b, required %0b", e.ch, data_err, e.err);
          end
        end
      end
    end
  end

  task automatic push_word(input int ch, input logic [W-1:0] bin, input logic err);
    exp_t e;
    e.ch   = CW'(ch);
    e.data = bin - prev_m[ch];
    e.err  = err;
    sb.push_back(e);
    prev_m[ch] = bin;
  endtask

  task automatic push_scan();
    for (int ch = 0; ch < N_CH; ch++) push_word(ch, cnt[ch], 1'b0);
  endtask

  // Pulses start; returns edges from the start-sampling edge to data_valid, and tog at that edge.
  task automatic launch(output int lat, output bit tk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    tk  = tog;
    lat = 0;
    while (!data_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_done(input int base, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (done_seen > base && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    #3;
    checks++; if (ch_sel !== '0)     begin errors++; $display("FAIL reset_ch_sel: got %0d, required 0", ch_sel); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    checks++; if (data_out !== '0)   begin errors++; $display("FAIL reset_data_out: got %0d, required 0", data_out); end
    checks++; if (data_ch !== '0)    begin errors++; $display("FAIL reset_data_ch: got %0d, required 0", data_ch); end
    checks++; if (data_err !== 1'b0) begin errors++; $display("FAIL reset_data_err: got %0b, required 0", data_err); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %0b, required 0", data_valid); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %0b, required 0", done); end
    @(negedge clk) rstb = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic check_scan_end(input string name, input bit ok, input int bw, input int bd, input int nw);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: got no done, required done within bound", name); end
    checks++; if (words_seen - bw != nw) begin errors++; $display("FAIL %s_words: got %0d, required %0d", name, words_seen - bw, nw); end
    checks++; if (done_seen - bd != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d, required 1", name, done_seen - bd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %0b, required 0", name, busy); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL %s_pending: got %0d words left, required 0", name, sb.size()); end
    $display("%s: words=%0d done_pulses=%0d", name, words_seen - bw, done_seen - bd);
  endtask

  task automatic test_basic();
    int lat; bit tk, ok; int bw, bd;
    for (int ch = 0; ch < N_CH; ch++) cnt[ch] = W'(10 * ch);
    bw = words_seen; bd = done_seen;
    push_scan();
    launch(lat, tk);
    checks++;
    if (lat != SETTLE + 3) begin errors++; $display("FAIL basic_latency: got %0d, required %0d", lat, SETTLE + 3); end
    wait_done(bd, ok);
    checks++;
    if (ch_sel !== '0) begin errors++; $display("FAIL basic_ch_sel_idle: got %0d, required 0", ch_sel); end
    check_scan_end("test_basic", ok, bw, bd, N_CH);
  endtask

  task automatic test_delta_wrap();
    int lat; bit tk, ok; int bw, bd;
    cnt[3] = 8'd250;
    bw = words_seen; bd = done_seen;
    push_scan();
    launch(lat, tk);
    wait_done(bd, ok);
    check_scan_end("test_delta_setup", ok, bw, bd, N_CH);
    cnt[3] = 8'd4;
    bw = words_seen; bd = done_seen;
    for (int ch = 0; ch < N_CH; ch++) begin
      exp_t e;
      e.ch = CW'(ch); e.data = (ch == 3) ? 8'd10 : 8'd0; e.err = 1'b0;
      sb.push_back(e);
      prev_m[ch] = cnt[ch];
    end
    launch(lat, tk);
    wait_done(bd, ok);
    check_scan_end("test_delta_wrap", ok, bw, bd, N_CH);
  endtask

  task automatic test_backpressure();
    int lat; bit tk, ok; int bw, bd; int hold = 0; int n = 0; bit seen = 1'b0;
    logic [W-1:0] exp2;
    for (int ch = 0; ch < N_CH; ch++) cnt[ch] = cnt[ch] + W'(ch + 1);
    exp2 = cnt[2] - prev_m[2];
    bw = words_seen; bd = done_seen;
    push_scan();
    data_ready = 1'b1;
    launch(lat, tk);
    while (n < 3000) begin
      if (!seen && data_valid && data_ch == 3'd2) seen = 1'b1;
      if (seen && hold < 7) begin
        data_ready = 1'b0;
        hold++;
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d: got %0b, required 1", hold, data_valid); end
        checks++; if (data_ch !== 3'd2) begin errors++; $display("FAIL bp_data_ch cyc%0d: got %0d, required 2", hold, data_ch); end
        checks++; if (data_out !== exp2) begin errors++; $display("FAIL bp_data_out cyc%0d: got %0d, required %0d", hold, data_out, exp2); end
        checks++; if (ch_sel !== 3'd2) begin errors++; $display("FAIL bp_ch_sel cyc%0d: got %0d, required 2", hold, ch_sel); end
      end else begin
        data_ready = 1'b1;
      end
      if (done_seen > bd && !busy) break;
      @(posedge clk); #1;
      n++;
    end
    data_ready = 1'b1;
    ok = (done_seen > bd);
    checks++;
    if (hold != 7) begin errors++; $display("FAIL bp_hold_cycles: got %0d, required 7", hold); end
    @(negedge clk);
    check_scan_end("test_backpressure", ok, bw, bd, N_CH);
  endtask

  task automatic test_instability();
    int lat; bit tk, ok; int bw, bd; bit flip;
    logic [W-1:0] g0;
    for (int ch = 0; ch < N_CH; ch++) cnt[ch] = cnt[ch] + W'(3 * ch + 7);
    inst_en = 1'b1;
    bw = words_seen; bd = done_seen;
    launch(lat, tk);
    // Last s1 is taken SETTLE+2+2*(MAX_RETRY-1) edges after the start edge.
    flip = tk ^ bit'((SETTLE + 2 + 2 * (MAX_RETRY - 1)) % 2);
    g0 = to_gray(cnt[0]) ^ {{(W-1){1'b0}}, flip};
    push_word(0, gray2bin(g0), 1'b1);
    for (int ch = 1; ch < N_CH; ch++) push_word(ch, cnt[ch], 1'b0);
    checks++;
    if (lat != SETTLE + 3 + 4) begin errors++; $display("FAIL inst_latency: got %0d, required %0d", lat, SETTLE + 7); end
    wait_done(bd, ok);
    inst_en = 1'b0;
    check_scan_end("test_instability", ok, bw, bd, N_CH);
  endtask

  task automatic test_reset_midscan();
    int lat; bit tk, ok; int bw, bd; int n = 0; bit hit = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) cnt[ch] = cnt[ch] + W'(5 * ch + 2);
    bw = words_seen; bd = done_seen;
    push_scan();
    data_ready = 1'b1;
    launch(lat, tk);
    while (n < 2000) begin
      if (data_valid && data_ch == 3'd4) begin
        data_ready = 1'b0;
        hit = 1'b1;
        break;
      end
      data_ready = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_mid_reach_ch4: got no ch4 word, required one within bound"); end
    #2 rstb = 1'b0;
    #1;
    checks++; if (ch_sel !== '0)       begin errors++; $display("FAIL rst_mid_ch_sel: got %0d, required 0", ch_sel); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy: got %0b, required 0", busy); end
    checks++; if (data_out !== '0)     begin errors++; $display("FAIL rst_mid_data_out: got %0d, required 0", data_out); end
    checks++; if (data_ch !== '0)      begin errors++; $display("FAIL rst_mid_data_ch: got %0d, required 0", data_ch); end
    checks++; if (data_err !== 1'b0)   begin errors++; $display("FAIL rst_mid_data_err: got %0b, required 0", data_err); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_data_valid: got %0b, required 0", data_valid); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_mid_done: got %0b, required 0", done); end
    checks++; if (words_seen - bw != 4) begin errors++; $display("FAIL rst_mid_partial_words: got %0d, required 4", words_seen - bw); end
    sb.delete();
    for (int ch = 0; ch < N_CH; ch++) prev_m[ch] = '0;
    @(negedge clk) rstb = 1'b1;
    data_ready = 1'b1;
    bw = words_seen; bd = done_seen;
    push_scan();
    launch(lat, tk);
    wait_done(bd, ok);
    check_scan_end("test_reset_midscan", ok, bw, bd, N_CH);
  endtask

  task automatic test_start_busy();
    int lat; bit tk, ok; int bw, bd;
    for (int ch = 0; ch < N_CH; ch++) cnt[ch] = cnt[ch] - W'(ch + 9);
    bw = words_seen; bd = done_seen;
    push_scan();
    launch(lat, tk);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(bd, ok);
    repeat (4) @(negedge clk);
    check_scan_end("test_start_busy", ok, bw, bd, N_CH);
  endtask

  initial begin
    for (int ch = 0; ch < N_CH; ch++) begin
      cnt[ch]    = '0;
      prev_m[ch] = '0;
    end
    test_reset();
    test_basic();
    test_delta_wrap();
    test_backpressure();
    test_instability();
    test_reset_midscan();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
